// File: rtl/line_buffer_taps_pkg.sv
// Shared constants and helpers for the multi-line buffer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package line_buffer_taps_pkg;

  localparam int PIX_WIDTH_DEF = 10;  // default bits per pixel
  localparam int COL_WIDTH_DEF = 11;  // default column address width
  localparam int ROW_WIDTH     = 16;  // line-in-frame counter width

  // Bank holding line n-k while line n is being written into bank 'ptr'.
  // Valid for 0 <= ptr < nbanks and 1 <= k <= nbanks; k == nbanks lands on
  // the writing bank itself, whose read-first port returns the oldest line.
  function automatic int tap_bank_idx(input int ptr, input int k, input int nbanks);
    int idx;
    idx = ptr + nbanks - k;
    if (idx >= nbanks) idx = idx - nbanks;
    return idx;
  endfunction

endpackage

// File: rtl/line_buffer_taps_bank.sv
// One stored video line: 1R1W single-clock RAM, read-first, registered read data.
// Latency: read data valid 1 cycle after re; holds when re is low.
// Backpressure: none; accepts a write and a read every cycle.
module line_bank
  import line_buffer_taps_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_WIDTH_DEF,
  parameter int ADDR_WIDTH = COL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Same-address read and write return the old word (read-first).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_taps.sv
// Line buffer: stores the last NUM_TAPS-1 lines and emits a column-aligned vertical window.
// Latency: 1 cycle from i_de/i_data to o_de/o_taps/o_col/o_row/o_rows_valid.
// Backpressure: none; o_de mirrors i_de delayed, taps hold while o_de is low.
module line_buffer_taps
  import line_buffer_taps_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_WIDTH_DEF,
  parameter int ADDR_WIDTH = COL_WIDTH_DEF,
  parameter int NUM_TAPS   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_vs,
  input  logic                           i_de,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_de,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] o_taps,
  output logic [ADDR_WIDTH-1:0]          o_col,
  output logic [ROW_WIDTH-1:0]           o_row,
  output logic                           o_rows_valid,
  output logic                           o_ovf
);

  localparam int NUM_BANKS = NUM_TAPS - 1;
  localparam int PTR_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int FILL_W    = $clog2(NUM_BANKS + 1);

  localparam logic [ADDR_WIDTH-1:0] COL_MAX   = '1;
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(NUM_BANKS - 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(NUM_BANKS);

  // Frame/line tracking state.
  logic                  vs_d;
  logic                  de_d;
  logic [PTR_W-1:0]      ptr;
  logic [FILL_W-1:0]     fill;
  logic [ROW_WIDTH-1:0]  row;
  logic [ADDR_WIDTH-1:0] wr_col;
  logic                  col_sat;   // last column already written this line

  // Effective values for this cycle (a frame sync overrides stored state).
  logic                  vs_rise;
  logic                  line_end;
  logic [PTR_W-1:0]      cur_ptr;
  logic [FILL_W-1:0]     cur_fill;
  logic [ROW_WIDTH-1:0]  cur_row;
  logic [ADDR_WIDTH-1:0] cur_col;
  logic                  cur_sat;

  // Bank interface.
  logic [NUM_BANKS-1:0]  bank_we;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  // Output-stage state captured with each accepted pixel.
  logic [DATA_WIDTH-1:0] slice0;
  logic [PTR_W-1:0]      sel_ptr;
  logic [FILL_W-1:0]     sel_fill;
  logic [PTR_W-1:0]      tap_idx;

  assign vs_rise  = i_vs & ~vs_d;
  assign line_end = de_d & ~i_de;

  // A frame sync restarts everything, so a pixel arriving with it lands at col 0, row 0, bank 0.
  always_comb begin
    cur_ptr  = ptr;
    cur_fill = fill;
    cur_row  = row;
    cur_col  = wr_col;
    cur_sat  = col_sat;
    if (vs_rise) begin
      cur_ptr  = '0;
      cur_fill = '0;
      cur_row  = '0;
      cur_col  = '0;
      cur_sat  = 1'b0;
    end
  end

  // Only the bank owned by the current line is written; overflowing pixels are dropped.
  always_comb begin
    bank_we = '0;
    if (i_de && !cur_sat) bank_we[cur_ptr] = 1'b1;
  end

  // Edge detectors, column/row/fill counters, bank pointer and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d    <= 1'b0;
      de_d    <= 1'b0;
      ptr     <= '0;
      fill    <= '0;
      row     <= '0;
      wr_col  <= '0;
      col_sat <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      vs_d <= i_vs;
      de_d <= i_de;
      if (vs_rise) begin
        ptr     <= '0;
        fill    <= '0;
        row     <= '0;
        wr_col  <= '0;
        col_sat <= 1'b0;
        o_ovf   <= 1'b0;
      end else if (line_end) begin
        ptr     <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
        row     <= row + ROW_WIDTH'(1);
        wr_col  <= '0;
        col_sat <= 1'b0;
      end
      // line_end implies i_de is low, so this never collides with the branch above.
      if (i_de) begin
        if (cur_sat)                 o_ovf   <= 1'b1;
        else if (cur_col == COL_MAX) col_sat <= 1'b1;
        else                         wr_col  <= cur_col + ADDR_WIDTH'(1);
      end
    end
  end

  // All banks are read at the write column so their outputs line up with the delayed pixel.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    line_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (cur_col),
      .wdata (i_data),
      .re    (i_de),
      .raddr (cur_col),
      .rdata (bank_rdata[b])
    );
  end

  // Output register: window metadata and the selectors for the tap mux, held while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_de         <= 1'b0;
      o_rows_valid <= 1'b0;
      o_col        <= '0;
      o_row        <= '0;
      slice0       <= '0;
      sel_ptr      <= '0;
      sel_fill     <= '0;
    end else begin
      o_de         <= i_de;
      o_rows_valid <= i_de && (cur_fill == FILL_FULL);
      if (i_de) begin
        o_col    <= cur_col;
        o_row    <= cur_row;
        slice0   <= i_data;
        sel_ptr  <= cur_ptr;
        sel_fill <= cur_fill;
      end
    end
  end

  // Tap mux: slice k comes from the bank holding line n-k; lines not yet stored read as 0.
  always_comb begin
    o_taps                 = '0;
    tap_idx                = '0;
    o_taps[DATA_WIDTH-1:0] = slice0;
    for (int k = 1; k < NUM_TAPS; k++) begin
      tap_idx = PTR_W'(tap_bank_idx(int'(sel_ptr), k, NUM_BANKS));
      if (FILL_W'(k) <= sel_fill) o_taps[k*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[tap_idx];
    end
  end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Bench for line_buffer_taps: NUM_TAPS=3 and NUM_TAPS=5 instances share one stimulus stream.
// Latency: expected window for each driven cycle is queued and compared after the next edge.
// Backpressure: none; the DUT never stalls.
module tb_line_buffer_taps;

  localparam int DW      = 10;
  localparam int AW      = 11;
  localparam int COL_MAX = (1 << AW) - 1;
  localparam logic [29:0] WIN_L2C5 = {10'h005, 10'h015, 10'h025};

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic i_vs   = 1'b0;
  logic i_de   = 1'b0;
  logic [DW-1:0] i_data = '0;

  logic          o_de3, o_rv3, o_ovf3;
  logic [29:0]   o_taps3;
  logic [AW-1:0] o_col3;
  logic [15:0]   o_row3;
  logic          o_de5, o_rv5, o_ovf5;
  logic [49:0]   o_taps5;
  logic [AW-1:0] o_col5;
  logic [15:0]   o_row5;

  always #5 clk = ~clk;

  line_buffer_taps #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_de(o_de3), .o_taps(o_taps3), .o_col(o_col3), .o_row(o_row3),
    .o_rows_valid(o_rv3), .o_ovf(o_ovf3)
  );

  line_buffer_taps #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(5)) u_dut5 (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_de(o_de5), .o_taps(o_taps5), .o_col(o_col5), .o_row(o_row5),
    .o_rows_valid(o_rv5), .o_ovf(o_ovf5)
  );

  typedef struct packed {
    logic        de;
    logic [49:0] taps5;
    logic [29:0] taps3;
    logic [10:0] col;
    logic [15:0] row;
    logic        rv3;
    logic        rv5;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: lines written since the last sync, keyed by row*4096+col.
  int lines[int];
  int m_row, m_col;
  bit m_de_d, m_vs_d, m_ovf;
  bit chk_win;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_row  = 0;
    m_col  = 0;
    m_de_d = 1'b0;
    m_vs_d = 1'b0;
    m_ovf  = 1'b0;
    lines.delete();
    last_e = '0;
  endfunction

  function automatic logic [49:0] window(input int n, input int c, input logic [DW-1:0] d);
    logic [49:0] w;
    int key;
    w = '0;
    w[DW-1:0] = d;
    for (int k = 1; k < n; k++) begin
      key = (m_row - k) * 4096 + c;
      if (m_row >= k && lines.exists(key)) w[k*DW +: DW] = DW'(lines[key]);
    end
    return w;
  endfunction

  // One clock of stimulus: predict, push, clock, pop and compare.
  task automatic step(input bit vs, input bit de, input logic [DW-1:0] d);
    exp_t e;
    int   c;
    i_vs   = vs;
    i_de   = de;
    i_data = d;
    if (vs && !m_vs_d) begin
      m_row = 0; m_col = 0; m_ovf = 1'b0; lines.delete();
    end else if (m_de_d && !de) begin
      m_row++; m_col = 0;
    end
    e     = last_e;
    e.de  = de;
    e.rv3 = 1'b0;
    e.rv5 = 1'b0;
    if (de) begin
      c       = (m_col > COL_MAX) ? COL_MAX : m_col;
      e.col   = 11'(c);
      e.row   = 16'(m_row);
      e.taps3 = 30'(window(3, c, d));
      e.taps5 = window(5, c, d);
      e.rv3   = (m_row >= 2);
      e.rv5   = (m_row >= 4);
      if (m_col <= COL_MAX) lines[m_row * 4096 + m_col] = int'(d);
      else m_ovf = 1'b1;
      m_col++;
    end
    e.ovf  = m_ovf;
    m_vs_d = vs;
    m_de_d = de;
    last_e = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("de3",   64'(o_de3),   64'(e.de));
    check("de5",   64'(o_de5),   64'(e.de));
    check("taps3", 64'(o_taps3), 64'(e.taps3));
    check("taps5", 64'(o_taps5), 64'(e.taps5));
    check("rv3",   64'(o_rv3),   64'(e.rv3));
    check("rv5",   64'(o_rv5),   64'(e.rv5));
    check("ovf3",  64'(o_ovf3),  64'(e.ovf));
    check("ovf5",  64'(o_ovf5),  64'(e.ovf));
    if (e.de) begin
      check("col3", 64'(o_col3), 64'(e.col));
      check("row3", 64'(o_row3), 64'(e.row));
      check("col5", 64'(o_col5), 64'(e.col));
      check("row5", 64'(o_row5), 64'(e.row));
      if (chk_win && e.row == 16'd2 && e.col == 11'd5)
        check("win_l2c5", 64'(o_taps3), 64'(WIN_L2C5));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_de3"},   64'(o_de3),   64'd0);
    check({tag, "_taps3"}, 64'(o_taps3), 64'd0);
    check({tag, "_col3"},  64'(o_col3),  64'd0);
    check({tag, "_row3"},  64'(o_row3),  64'd0);
    check({tag, "_rv3"},   64'(o_rv3),   64'd0);
    check({tag, "_ovf3"},  64'(o_ovf3),  64'd0);
    check({tag, "_de5"},   64'(o_de5),   64'd0);
    check({tag, "_taps5"}, 64'(o_taps5), 64'd0);
    check({tag, "_col5"},  64'(o_col5),  64'd0);
    check({tag, "_row5"},  64'(o_row5),  64'd0);
    check({tag, "_rv5"},   64'(o_rv5),   64'd0);
    check({tag, "_ovf5"},  64'(o_ovf5),  64'd0);
  endtask

  task automatic send_line(input int len, input int n, input int base, input int gap);
    for (int c = 0; c < len; c++) step(1'b0, 1'b1, DW'(base + 16 * n + c));
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, '0);
  endtask

  task automatic vs_pulse();
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
  endtask

  initial begin
    model_reset();
    chk_win = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Frame A: 3 lines of 8 px, pixel = 16n+c.
    vs_pulse();
    chk_win = 1'b1;
    for (int n = 0; n < 3; n++) send_line(8, n, 0, 3);
    chk_win = 1'b0;

    // Frame B: 6 lines of 16 px; the 5-tap instance wraps past its last bank.
    vs_pulse();
    for (int n = 0; n < 6; n++) send_line(16, n, 'h100, 2);

    // Frame C: 5 lines, then a sync arriving together with the first pixel of a line.
    vs_pulse();
    for (int n = 0; n < 5; n++) send_line(8, n, 'h080, 2);
    for (int c = 0; c < 8; c++) step(c < 2, 1'b1, DW'('h300 + c));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    for (int n = 1; n < 4; n++) send_line(8, n, 'h300, 1);

    // Overlong line: column saturates, overflow sticks until the next sync.
    vs_pulse();
    send_line(COL_MAX + 4, 0, 0, 2);
    for (int n = 1; n < 3; n++) send_line(8, n, 'h040, 2);
    vs_pulse();

    // Reset in the middle of line 2 at column 4.
    for (int n = 0; n < 2; n++) send_line(8, n, 'h1c0, 2);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, DW'('h200 + c));
    i_data = DW'('h204);
    rst    = 1'b1;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    i_de = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, '0);
    for (int n = 0; n < 3; n++) send_line(8, n, 'h220, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
